// File: rtl/fio_pkg.sv
// fio_pkg -- definitions shared by the fio_loader block.
//   FIO_OP_LOAD / FIO_OP_DUMP : cmd_op encodings
//   fio_state_e               : controller state encoding
package fio_pkg;

    localparam logic FIO_OP_LOAD = 1'b0;
    localparam logic FIO_OP_DUMP = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DUMP = 2'd2
    } fio_state_e;

endpackage

// File: rtl/fio_skid_fifo.sv
// fio_skid_fifo -- two-entry FIFO that buffers dump read data ahead of the
// output stream.
//   clk, rst      : clock, asynchronous active-low reset
//   push, wdata   : write one entry (ignored when full)
//   pop, rdata    : rdata shows the head entry; pop removes it (ignored when empty)
//   full, empty   : occupancy flags
//   count         : number of stored entries (0..2)
module fio_skid_fifo #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        cnt_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                mem_q[k] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr] <= wdata;
                wr_ptr        <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/fio_loader.sv
// fio_loader -- moves word streams into (LOAD) or out of (DUMP) one of
// NUM_CH single-port memory channels.
//
// Build option: define FIO_LOADER_DUMP_EN to include the DUMP state, the
// read path and the output FIFO. Without it a dump command is rejected
// with an err pulse and the read/output ports are tied low.
//
// Ports
//   clk, rst                         : clock, asynchronous active-low reset
//   cmd_valid/ready, cmd_op, cmd_ch,
//   cmd_base, cmd_len                : command handshake (op 0 = load, 1 = dump)
//   in_valid/ready, in_data          : load data stream
//   out_valid/ready, out_data,
//   out_last                         : dump data stream
//   mem_wen, mem_ren                 : per-channel write / read strobes
//   mem_addr, mem_wdata              : broadcast address and write data
//   mem_rdata                        : channel k at [k*DATA_W +: DATA_W], one cycle after mem_ren
//   busy, done, err                  : status (done/err are single-cycle pulses)
//
// State | meaning
// IDLE  | waiting for a command, cmd_ready high
// LOAD  | accepting load beats, then retiring the last registered write
// DUMP  | issuing reads and draining words through the output FIFO
module fio_loader
    import fio_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 256,
    parameter int ADDR_W = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_op,
    // one extra code point so ids beyond the last channel can be presented and rejected
    input  logic [$clog2(NUM_CH+1)-1:0] cmd_ch,
    input  logic [ADDR_W-1:0]           cmd_base,
    input  logic [ADDR_W:0]             cmd_len,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    output logic [NUM_CH-1:0]           mem_wen,
    output logic [NUM_CH-1:0]           mem_ren,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [NUM_CH*DATA_W-1:0]    mem_rdata,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int CH_W = $clog2(NUM_CH + 1);
`ifdef FIO_LOADER_DUMP_EN
    localparam bit DUMP_EN = 1'b1;
`else
    localparam bit DUMP_EN = 1'b0;
`endif

    fio_state_e        state;
    fio_state_e        state_nxt;
    logic              ready_q;
    logic [CH_W-1:0]   ch_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   idx_q;      // load beats accepted, or dump reads issued
    logic [NUM_CH-1:0] wen_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              done_q;
    logic              done_nxt;
    logic              err_q;
    logic              err_nxt;
    logic              accept;
    logic              beat;
    logic              idx_end;
    logic              dump_step;
    logic              dump_fin;
    logic [NUM_CH-1:0] ch_onehot;
    logic [ADDR_W-1:0] cur_addr;

    // ready_q keeps cmd_ready low while reset is asserted
    assign cmd_ready = ready_q && (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign idx_end   = (idx_q == len_q);
    assign in_ready  = (state == LOAD) && !idx_end;
    assign beat      = in_valid && in_ready;
    assign cur_addr  = base_q + idx_q[ADDR_W-1:0];   // wraps modulo 2^ADDR_W

    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign err       = err_q;

    always_comb begin
        ch_onehot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_onehot[k] = (ch_q == CH_W'(k));
        end
    end

`ifdef FIO_LOADER_DUMP_EN
    logic              rvalid_q;   // a read issued last cycle returns data now
    logic [ADDR_W:0]   out_idx_q;
    logic [DATA_W-1:0] rd_word;
    logic              pop;
    logic              f_full;
    logic              f_empty;
    logic [1:0]        f_count;
    logic              unused_dump;

    // FIFO occupancy plus the in-flight read must leave room for the new word
    assign dump_step = (state == DUMP) && !idx_end &&
                       (({1'b0, f_count} + {2'b00, rvalid_q}) < 3'd2);
    assign out_valid = !f_empty;
    assign pop       = out_valid && out_ready;
    assign out_last  = out_valid && (out_idx_q == len_q - 1'b1);
    assign dump_fin  = pop && out_last;
    assign mem_ren   = dump_step ? ch_onehot : '0;
    assign mem_addr  = (state == DUMP) ? cur_addr : waddr_q;
    assign busy      = (state != IDLE) || !f_empty;
    assign unused_dump = f_full;

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == CH_W'(k)) begin
                rd_word = mem_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_q  <= 1'b0;
            out_idx_q <= '0;
        end else begin
            rvalid_q <= dump_step;
            if (accept) begin
                out_idx_q <= '0;
            end else if (pop) begin
                out_idx_q <= out_idx_q + 1'b1;
            end
        end
    end

    fio_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rvalid_q),
        .pop   (pop),
        .wdata (rd_word),
        .rdata (out_data),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );
`else
    logic unused_dump;

    assign dump_step   = 1'b0;
    assign dump_fin    = 1'b0;
    assign out_valid   = 1'b0;
    assign out_last    = 1'b0;
    assign out_data    = '0;
    assign mem_ren     = '0;
    assign mem_addr    = waddr_q;
    assign busy        = (state != IDLE);
    assign unused_dump = ^{mem_rdata, out_ready};
`endif

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if ((cmd_ch >= CH_W'(NUM_CH)) || ((cmd_op == FIO_OP_DUMP) && !DUMP_EN)) begin
                        err_nxt = 1'b1;
                    end else if (cmd_len == '0) begin
                        done_nxt = 1'b1;
                    end else if (cmd_op == FIO_OP_DUMP) begin
                        state_nxt = DUMP;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                // idx_end is reached in the cycle the last write is on the bus
                if (idx_end) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            DUMP: begin
                if (dump_fin) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            ch_q    <= '0;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            wen_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= 1'b1;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
            if (accept) begin
                ch_q   <= cmd_ch;
                base_q <= cmd_base;
                len_q  <= cmd_len;
                idx_q  <= '0;
            end else if (beat || dump_step) begin
                idx_q <= idx_q + 1'b1;
            end
            wen_q <= beat ? ch_onehot : '0;
            if (beat) begin
                waddr_q <= cur_addr;
                wdata_q <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_fio_loader.sv
module tb_fio_loader;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 9;
    localparam int CH_W   = $clog2(NUM_CH + 1);

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     cmd_valid = 1'b0;
    logic                     cmd_ready;
    logic                     cmd_op = 1'b0;
    logic [CH_W-1:0]          cmd_ch = '0;
    logic [ADDR_W-1:0]        cmd_base = '0;
    logic [ADDR_W:0]          cmd_len = '0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [DATA_W-1:0]        out_data;
    logic                     out_last;
    logic [NUM_CH-1:0]        mem_wen;
    logic [NUM_CH-1:0]        mem_ren;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic [NUM_CH*DATA_W-1:0] mem_rdata;
    logic                     busy;
    logic                     done;
    logic                     err;

    int vectors     = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] mem_model [NUM_CH][1<<ADDR_W];
    logic [DATA_W-1:0] rd_q [NUM_CH];

    fio_loader #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_ch    (cmd_ch),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // memory channels: synchronous write, one-cycle read latency
    always @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (mem_wen[k]) mem_model[k][mem_addr] <= mem_wdata;
            if (mem_ren[k]) rd_q[k] <= mem_model[k][mem_addr];
        end
    end

    always_comb begin
        mem_rdata = '0;
        for (int k = 0; k < NUM_CH; k++) mem_rdata[k*DATA_W +: DATA_W] = rd_q[k];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic op, input logic [CH_W-1:0] ch,
                             input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
        int guard = 0;
        while (cmd_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ch    = ch;
        cmd_base  = base;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        vectors++;
        if ({cmd_ready, in_ready, busy, done, err, out_valid} !== 6'b0 || mem_wen !== '0 || mem_ren !== '0 || mem_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b inrdy=%b busy=%b done=%b err=%b oval=%b wen=%b ren=%b addr=%h, want all 0",
                     cmd_ready, in_ready, busy, done, err, out_valid, mem_wen, mem_ren, mem_addr);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got cmd_ready=%b busy=%b, want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_load();
        issue_cmd(fio_pkg::FIO_OP_LOAD, 3'd2, 9'h010, 10'd4);
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL load_enter: got in_ready=%b busy=%b, want 1 1", in_ready, busy);
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(16'h000A + i);
            tick();
            vectors++;
            if (mem_wen !== 4'b0100 || mem_addr !== ADDR_W'(9'h010 + i) || mem_wdata !== DATA_W'(16'h000A + i) || done !== 1'b0) begin
                miscompares++;
                $display("FAIL load_write[%0d]: got wen=%b addr=%h data=%h done=%b, want 0100 %h %h 0",
                         i, mem_wen, mem_addr, mem_wdata, done, 9'h010 + i, 16'h000A + i);
            end
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL load_in_ready_drop: got %b want 0", in_ready);
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (done !== 1'b1 || mem_wen !== '0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL load_done: got done=%b wen=%b busy=%b rdy=%b, want 1 0000 0 1", done, mem_wen, busy, cmd_ready);
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL load_done_pulse: got done=%b want 0", done);
        end
    endtask

    task automatic test_addr_wrap();
        logic [ADDR_W-1:0] exp_addr [4];
        exp_addr[0] = 9'h1FE;
        exp_addr[1] = 9'h1FF;
        exp_addr[2] = 9'h000;
        exp_addr[3] = 9'h001;
        issue_cmd(fio_pkg::FIO_OP_LOAD, 3'd0, 9'h1FE, 10'd4);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(16'h0100 + i);
            tick();
            vectors++;
            if (mem_wen !== 4'b0001 || mem_addr !== exp_addr[i] || err !== 1'b0) begin
                miscompares++;
                $display("FAIL wrap_write[%0d]: got wen=%b addr=%h err=%b, want 0001 %h 0", i, mem_wen, mem_addr, err, exp_addr[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_done: got %b want 1", done);
        end
    endtask

    task automatic test_bad_cmd();
        issue_cmd(fio_pkg::FIO_OP_LOAD, 3'd5, 9'h020, 10'd3);
        vectors++;
        if (err !== 1'b1 || done !== 1'b0 || mem_wen !== '0 || mem_ren !== '0 || cmd_ready !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_ch: got err=%b done=%b wen=%b ren=%b rdy=%b inrdy=%b, want 1 0 0000 0000 1 0",
                     err, done, mem_wen, mem_ren, cmd_ready, in_ready);
        end
        tick();
        vectors++;
        if (err !== 1'b0 || mem_wen !== '0) begin
            miscompares++;
            $display("FAIL bad_ch_pulse: got err=%b wen=%b, want 0 0000", err, mem_wen);
        end
        issue_cmd(fio_pkg::FIO_OP_LOAD, 3'd1, 9'h030, 10'd0);
        vectors++;
        if (done !== 1'b1 || err !== 1'b0 || cmd_ready !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_len: got done=%b err=%b rdy=%b inrdy=%b, want 1 0 1 0", done, err, cmd_ready, in_ready);
        end
        tick();
    endtask

`ifdef FIO_LOADER_DUMP_EN
    task automatic test_dump();
        logic [DATA_W-1:0] held;
        logic              held_v;
        int                n;
        int                cyc;
        issue_cmd(fio_pkg::FIO_OP_DUMP, 3'd2, 9'h010, 10'd4);
        n      = 0;
        cyc    = 0;
        held_v = 1'b0;
        held   = '0;
        while (n < 4 && cyc < 80) begin
            out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            vectors++;
            if (mem_wen !== '0 || (mem_ren !== '0 && mem_ren !== 4'b0100)) begin
                miscompares++;
                $display("FAIL dump_strobes: got wen=%b ren=%b, want 0000 and ren 0000/0100", mem_wen, mem_ren);
            end
            if (held_v) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    miscompares++;
                    $display("FAIL dump_hold: got valid=%b data=%h, want 1 %h", out_valid, out_data, held);
                end
            end
            held_v = 1'b0;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    vectors++;
                    if (out_data !== DATA_W'(16'h000A + n) || out_last !== (n == 3)) begin
                        miscompares++;
                        $display("FAIL dump_word[%0d]: got data=%h last=%b, want %h %b", n, out_data, out_last, 16'h000A + n, n == 3);
                    end
                    n++;
                end else begin
                    held_v = 1'b1;
                    held   = out_data;
                end
            end
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        vectors++;
        if (n != 4) begin
            miscompares++;
            $display("FAIL dump_timeout: got %0d words want 4", n);
        end
        vectors++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL dump_done: got done=%b oval=%b busy=%b rdy=%b, want 1 0 0 1", done, out_valid, busy, cmd_ready);
        end
        tick();
    endtask
`else
    task automatic test_dump_disabled();
        cmd_valid = 1'b1;
        cmd_op    = fio_pkg::FIO_OP_DUMP;
        cmd_ch    = 3'd2;
        cmd_base  = 9'h010;
        cmd_len   = 10'd4;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL dump_off_ready: got %b want 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        vectors++;
        if (err !== 1'b1 || done !== 1'b0 || mem_ren !== '0 || out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL dump_off_err: got err=%b done=%b ren=%b oval=%b rdy=%b, want 1 0 0000 0 1",
                     err, done, mem_ren, out_valid, cmd_ready);
        end
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b1;
            tick();
            vectors++;
            if (mem_ren !== '0 || out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL dump_off_idle[%0d]: got ren=%b oval=%b odata=%h busy=%b, want 0", i, mem_ren, out_valid, out_data, busy);
            end
        end
        out_ready = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_load();
        issue_cmd(fio_pkg::FIO_OP_LOAD, 3'd1, 9'h040, 10'd8);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(16'h0200 + i);
            tick();
        end
        vectors++;
        if (mem_wen !== 4'b0010 || mem_addr !== 9'h041) begin
            miscompares++;
            $display("FAIL midload_pre: got wen=%b addr=%h, want 0010 041", mem_wen, mem_addr);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (mem_wen !== '0 || {cmd_ready, in_ready, busy, done, err} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            miscompares++;
            $display("FAIL midload_reset: got wen=%b rdy=%b inrdy=%b busy=%b done=%b err=%b addr=%h wdata=%h, want all 0",
                     mem_wen, cmd_ready, in_ready, busy, done, err, mem_addr, mem_wdata);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (mem_wen !== '0 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL midload_hold[%0d]: got wen=%b inrdy=%b, want 0000 0", i, mem_wen, in_ready);
            end
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (mem_wen !== '0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midload_release: got wen=%b rdy=%b busy=%b, want 0000 1 0", mem_wen, cmd_ready, busy);
        end
        in_valid = 1'b0;
        issue_cmd(fio_pkg::FIO_OP_LOAD, 3'd3, 9'h020, 10'd2);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(16'h0300 + i);
            tick();
            vectors++;
            if (mem_wen !== 4'b1000 || mem_addr !== ADDR_W'(9'h020 + i) || mem_wdata !== DATA_W'(16'h0300 + i)) begin
                miscompares++;
                $display("FAIL reload_write[%0d]: got wen=%b addr=%h data=%h, want 1000 %h %h",
                         i, mem_wen, mem_addr, mem_wdata, 9'h020 + i, 16'h0300 + i);
            end
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reload_done: got done=%b busy=%b, want 1 0", done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_addr_wrap();
        test_bad_cmd();
`ifdef FIO_LOADER_DUMP_EN
        test_dump();
`else
        test_dump_disabled();
`endif
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
